// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared state, mode and width constants for the capture controller
package la_pkg;

   localparam int STATE_W = 4;

   localparam logic [STATE_W-1:0] ST_IDLE             = 4'd0;
   localparam logic [STATE_W-1:0] ST_MOVE_TO_POSITION = 4'd1;
   localparam logic [STATE_W-1:0] ST_IN_POSITION      = 4'd2;
   localparam logic [STATE_W-1:0] ST_CAPTURING        = 4'd3;
   localparam logic [STATE_W-1:0] ST_CAPTURED         = 4'd4;

   localparam logic [1:0] MODE_SINGLE      = 2'd0;
   localparam logic [1:0] MODE_INCREMENTAL = 2'd1;
   localparam logic [1:0] MODE_IMMEDIATE   = 2'd2;

endpackage

// File: rtl/la_capture_controller_if.sv
// rtl/la_capture_controller_if.sv - register-file and sample-BRAM bundle of the capture controller
interface la_capture_controller_if #(
   parameter int SAMPLE_DEPTH = 1024,
   parameter int LOC_WIDTH    = 16
);
   localparam int ADDR_WIDTH = (SAMPLE_DEPTH > 1) ? $clog2(SAMPLE_DEPTH) : 1;

   logic                  request_start;
   logic                  request_stop;
   logic [1:0]            trigger_mode;
   logic [LOC_WIDTH-1:0]  trigger_loc;
   logic [3:0]            state;
   logic [ADDR_WIDTH-1:0] read_pointer;
   logic [ADDR_WIDTH-1:0] write_pointer;
   logic [ADDR_WIDTH-1:0] trigger_addr;
   logic                  done;
   logic [ADDR_WIDTH-1:0] bram_addr;
   logic                  bram_we;

   // Register file / BRAM side
   modport master (
      output request_start, request_stop, trigger_mode, trigger_loc,
      input  state, read_pointer, write_pointer, trigger_addr, done, bram_addr, bram_we
   );

   // Capture controller side
   modport slave (
      input  request_start, request_stop, trigger_mode, trigger_loc,
      output state, read_pointer, write_pointer, trigger_addr, done, bram_addr, bram_we
   );

endinterface

// File: rtl/la_edge_detect.sv
// rtl/la_edge_detect.sv - registered rising-edge detector for register-file request levels
module la_edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic level_i,
   output logic rise_o
);
   logic prev_q;

   // Remember last cycle's level so a rise is current-high and previous-low
   always_ff @(posedge clk) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= level_i;
   end

   assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/la_capture_controller.sv
// rtl/la_capture_controller.sv - capture sequencer driving the sample BRAM write port and pointers
module la_capture_controller
   import la_pkg::*;
#(
   parameter int SAMPLE_DEPTH = 1024,
   parameter int LOC_WIDTH    = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trig,
   la_capture_controller_if.slave bus
);
   localparam int                    ADDR_WIDTH = (SAMPLE_DEPTH > 1) ? $clog2(SAMPLE_DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST       = ADDR_WIDTH'(SAMPLE_DEPTH - 1);

   logic [STATE_W-1:0]    state_q, state_d;
   logic [ADDR_WIDTH-1:0] rp_q, rp_d;
   logic [ADDR_WIDTH-1:0] wp_q, wp_d;
   logic [ADDR_WIDTH-1:0] ta_q, ta_d;
   logic [ADDR_WIDTH-1:0] loc_q, loc_d;
   logic [1:0]            mode_q, mode_d;
   logic                  start_edge, stop_edge, we;

   // Circular-buffer step without a modulo so non-power-of-two depths wrap correctly
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == LAST) ? '0 : p + ADDR_WIDTH'(1);
   endfunction

   // Pre-trigger count can never exceed the buffer minus the trigger sample itself
   function automatic logic [ADDR_WIDTH-1:0] clamp_loc(input logic [LOC_WIDTH-1:0] loc);
      if (32'(loc) > 32'(SAMPLE_DEPTH - 1)) return LAST;
      return ADDR_WIDTH'(loc);
   endfunction

   la_edge_detect u_start_edge (.clk(clk), .rst_n(rst_n), .level_i(bus.request_start), .rise_o(start_edge));
   la_edge_detect u_stop_edge  (.clk(clk), .rst_n(rst_n), .level_i(bus.request_stop),  .rise_o(stop_edge));

   // Write enable: every armed cycle, except incremental capture which writes only on trig
   always_comb begin
      we = 1'b0;
      case (state_q)
         ST_MOVE_TO_POSITION, ST_IN_POSITION: we = 1'b1;
         ST_CAPTURING: we = (mode_q == MODE_INCREMENTAL) ? trig : 1'b1;
         default:      we = 1'b0;
      endcase
   end

   // Sequencer next state: stop wins, start only from rest, otherwise per-state pointer motion
   always_comb begin
      state_d = state_q;
      rp_d    = rp_q;
      wp_d    = wp_q;
      ta_d    = ta_q;
      loc_d   = loc_q;
      mode_d  = mode_q;
      if (stop_edge) begin
         state_d = ST_IDLE;
      end else if (start_edge && (state_q == ST_IDLE || state_q == ST_CAPTURED)) begin
         if (bus.trigger_mode != 2'd3) begin
            mode_d = bus.trigger_mode;
            loc_d  = clamp_loc(bus.trigger_loc);
            rp_d   = '0;
            wp_d   = '0;
            ta_d   = '0;
            if (bus.trigger_mode == MODE_SINGLE)
               state_d = (clamp_loc(bus.trigger_loc) != '0) ? ST_MOVE_TO_POSITION : ST_IN_POSITION;
            else
               state_d = ST_CAPTURING;
         end
      end else begin
         case (state_q)
            ST_MOVE_TO_POSITION: begin
               wp_d = ptr_inc(wp_q);
               if (wp_q == loc_q - ADDR_WIDTH'(1)) state_d = ST_IN_POSITION;
            end
            ST_IN_POSITION: begin
               wp_d = ptr_inc(wp_q);
               if (trig) begin
                  ta_d = wp_q;
                  // With a full pre-trigger window the trigger sample is also the last one
                  state_d = (ptr_inc(wp_q) == rp_q) ? ST_CAPTURED : ST_CAPTURING;
               end else begin
                  rp_d = ptr_inc(rp_q);
               end
            end
            ST_CAPTURING: begin
               if (we) begin
                  wp_d = ptr_inc(wp_q);
                  if (mode_q == MODE_SINGLE) begin
                     if (ptr_inc(wp_q) == rp_q) state_d = ST_CAPTURED;
                  end else if (wp_q == LAST) begin
                     state_d = ST_CAPTURED;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Sequencer registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rp_q    <= '0;
         wp_q    <= '0;
         ta_q    <= '0;
         loc_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         rp_q    <= rp_d;
         wp_q    <= wp_d;
         ta_q    <= ta_d;
         loc_q   <= loc_d;
         mode_q  <= mode_d;
      end
   end

   assign bus.state         = state_q;
   assign bus.read_pointer  = rp_q;
   assign bus.write_pointer = wp_q;
   assign bus.trigger_addr  = ta_q;
   assign bus.done          = (state_q == ST_CAPTURED);
   assign bus.bram_addr     = wp_q;
   assign bus.bram_we       = we;

endmodule
